seg_scan_driver: RTL and testbench

Downstream display stage for the 2-D RNG: accepts a 14-bit random value from the generator, converts it to four BCD digits with a sequential shift-add-3 converter, and time-multiplexes the digits onto a common-anode 4-digit seven-segment display. It runs on the 500 Hz display clock, so each digit refreshes at 125 Hz. The scan never stalls: the previous number stays on the display until conversion of a new one completes.

---
 rtl/seg_scan_driver.sv | 92 +++++++++
 tb/tb_seg_scan_driver.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 14-bit binary to 4-digit BCD (shift-add-3) with common-anode 7-seg scan.
// Define SEG_LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module seg_scan_driver (
    input  logic        CLK500Hz,
    input  logic        rstn,
    input  logic [13:0] value_in,
    input  logic        load,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit_order,
    output logic [7:0]  digit_val
);
    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t      state, state_nx;
    logic [13:0] bin;
    logic [15:0] bcd, bcd_adj, disp;
    logic [3:0]  cnt, cur, blank;
    logic [1:0]  idx;

    function automatic logic [7:0] seg(input logic [3:0] d);
        case (d)
            4'd0: seg = 8'hC0;
            4'd1: seg = 8'hF9;
            4'd2: seg = 8'hA4;
            4'd3: seg = 8'hB0;
            4'd4: seg = 8'h99;
            4'd5: seg = 8'h92;
            4'd6: seg = 8'h82;
            4'd7: seg = 8'hF8;
            4'd8: seg = 8'h80;
            4'd9: seg = 8'h90;
            default: seg = 8'hFF;
        endcase
    endfunction

    always_comb begin
        state_nx = (state == IDLE)  ? (load ? SHIFT : IDLE) :
                   (state == SHIFT) ? ((cnt == 4'd0) ? LATCH : SHIFT) : IDLE;
    end

    always_ff @(posedge CLK500Hz or negedge rstn)
        if (!rstn) state <= IDLE;
        else       state <= state_nx;

    assign busy = (state != IDLE);

    always_comb begin
        bcd_adj = bcd;
        for (int k = 0; k < 4; k++)
            bcd_adj[4*k +: 4] = (bcd[4*k +: 4] >= 4'd5) ? bcd[4*k +: 4] + 4'd3 : bcd[4*k +: 4];
    end

    // A digit is blanked only if it and every more-significant digit are zero.
    always_comb begin
        cur = disp[{idx, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
        blank[3] = (disp[15:12] == 4'd0);
        blank[2] = blank[3] && (disp[11:8] == 4'd0);
        blank[1] = blank[2] && (disp[7:4] == 4'd0);
        blank[0] = 1'b0;
`else
        blank = 4'b0000;
`endif
    end

    always_ff @(posedge CLK500Hz or negedge rstn)
        if (!rstn) begin
            bin         <= '0;
            bcd         <= '0;
            cnt         <= '0;
            disp        <= '0;
            done        <= 1'b0;
            idx         <= '0;
            digit_order <= 4'hF;
            digit_val   <= 8'hFF;
        end else begin
            done        <= (state == LATCH);
            idx         <= idx + 2'd1;
            digit_order <= ~(4'b0001 << idx);
            digit_val   <= blank[idx] ? 8'hFF : seg(cur);
            if (state == IDLE && load) begin
                bin <= (value_in > 14'd9999) ? 14'd9999 : value_in;
                bcd <= '0;
                cnt <= 4'd13;
            end else if (state == SHIFT) begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
                cnt        <= cnt - 4'd1;
            end
            if (state == LATCH) disp <= bcd;
        end
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver; expected displays are queued at load
// and checked when done pulses, by decoding the scanned anode/cathode outputs.
module tb_seg_scan_driver;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        load = 1'b0;
    logic [13:0] value_in = '0;
    logic        busy, done;
    logic [3:0]  digit_order;
    logic [7:0]  digit_val;
    int          pass = 0;
    int          total = 0;
    int          exp_q[$];

    always #5 clk = ~clk;

    seg_scan_driver dut (
        .CLK500Hz(clk), .rstn(rstn), .value_in(value_in), .load(load),
        .busy(busy), .done(done), .digit_order(digit_order), .digit_val(digit_val)
    );

    function automatic logic [7:0] enc(int d);
        case (d)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_seg(int v, int i);
        int p;
        p = (i == 0) ? 1 : (i == 1) ? 10 : (i == 2) ? 100 : 1000;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (i > 0 && v < p) return 8'hFF;
`endif
        return enc((v / p) % 10);
    endfunction

    task automatic drive_load(int v, bit accept);
        value_in = v[13:0];
        load = 1'b1;
        if (accept) exp_q.push_back(v > 9999 ? 9999 : v);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(output int k, output int bc);
        k = 0;
        bc = 0;
        while (done !== 1'b1 && k < 40) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
            k++;
        end
    endtask

    task automatic capture(output logic [3:0][7:0] segs, output bit bad);
        segs = {4{8'h00}};
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            case (digit_order)
                4'b1110: segs[0] = digit_val;
                4'b1101: segs[1] = digit_val;
                4'b1011: segs[2] = digit_val;
                4'b0111: segs[3] = digit_val;
                default: bad = 1'b1;
            endcase
        end
    endtask

    function automatic int pop_exp();
        return (exp_q.size() > 0) ? exp_q.pop_front() : -1;
    endfunction

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, digit_order, digit_val} !== {2'b00, 4'hF, 8'hFF})
            $display("FAIL reset_state got %b %b %h %h want 0 0 f ff", busy, done, digit_order, digit_val);
        else pass++;
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (digit_order !== ~(4'b0001 << i) || digit_val !== exp_seg(0, i))
                $display("FAIL reset_scan%0d got %b %h want %b %h", i, digit_order, digit_val,
                         ~(4'b0001 << i), exp_seg(0, i));
            else pass++;
        end
    endtask

    task automatic test_convert(int v);
        int k, bc, e;
        logic [3:0][7:0] segs;
        bit bad;
        drive_load(v, 1'b1);
        total++;
        if (busy !== 1'b1) $display("FAIL busy_after_load(%0d) got %b want 1", v, busy);
        else pass++;
        wait_done(k, bc);
        total++;
        if (k !== 15 || bc !== 15 || busy !== 1'b0)
            $display("FAIL latency(%0d) got cycles=%0d busy_cycles=%0d busy=%b want 15 15 0", v, k, bc, busy);
        else pass++;
        e = pop_exp();
        @(negedge clk);
        total++;
        if (done !== 1'b0) $display("FAIL done_pulse(%0d) got %b want 0", v, done);
        else pass++;
        capture(segs, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bad || e < 0 || segs[i] !== exp_seg(e, i))
                $display("FAIL display(%0d) digit%0d got %h want %h (order_bad=%0d)", v, i, segs[i],
                         exp_seg(e, i), bad);
            else pass++;
        end
    endtask

    task automatic test_ignore_load();
        int k, bc, e, extra;
        logic [3:0][7:0] segs;
        bit bad;
        drive_load(1234, 1'b1);
        repeat (3) @(negedge clk);
        drive_load(5678, 1'b0);
        wait_done(k, bc);
        e = pop_exp();
        capture(segs, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bad || e < 0 || segs[i] !== exp_seg(e, i))
                $display("FAIL ignore_load digit%0d got %h want %h", i, segs[i], exp_seg(e, i));
            else pass++;
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0 || exp_q.size() !== 0)
            $display("FAIL ignore_load_queued got extra_done=%0d want 0", extra);
        else pass++;
    endtask

    task automatic test_reset_abort();
        int extra;
        logic [3:0][7:0] segs;
        bit bad;
        drive_load(8888, 1'b1);
        repeat (6) @(negedge clk);
        #2 rstn = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if ({busy, digit_order, digit_val} !== {1'b0, 4'hF, 8'hFF})
            $display("FAIL abort_async got %b %h %h want 0 f ff", busy, digit_order, digit_val);
        else pass++;
        @(negedge clk);
        rstn = 1'b1;
        capture(segs, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bad || segs[i] !== exp_seg(0, i))
                $display("FAIL abort_display digit%0d got %h want %h", i, segs[i], exp_seg(0, i));
            else pass++;
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) extra++;
        end
        total++;
        if (extra !== 0) $display("FAIL abort_no_done got %0d want 0", extra);
        else pass++;
    endtask

    task automatic test_back_to_back();
        int k, bc, e;
        logic [3:0][7:0] segs;
        bit bad;
        drive_load(5000, 1'b1);
        wait_done(k, bc);
        e = pop_exp();
        drive_load(7, 1'b1);
        total++;
        if (busy !== 1'b1) $display("FAIL b2b_accept got busy=%b want 1", busy);
        else pass++;
        capture(segs, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bad || e < 0 || segs[i] !== exp_seg(e, i))
                $display("FAIL b2b_first digit%0d got %h want %h", i, segs[i], exp_seg(e, i));
            else pass++;
        end
        wait_done(k, bc);
        total++;
        if (k >= 40) $display("FAIL b2b_timeout got %0d cycles want <40", k);
        else pass++;
        e = pop_exp();
        @(negedge clk);
        capture(segs, bad);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (bad || e < 0 || segs[i] !== exp_seg(e, i))
                $display("FAIL b2b_second digit%0d got %h want %h", i, segs[i], exp_seg(e, i));
            else pass++;
        end
    endtask

    initial begin
        test_reset();
        test_convert(1234);
        test_convert(16383);
        test_convert(42);
        test_convert(0);
        test_ignore_load();
        test_reset_abort();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
